// File: rtl/wb_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_pkg
// Purpose : shared constants for the Wishbone UART transmitter slice:
//           bus widths, register word indices, STATUS bit positions and the
//           TX state encoding.
// Ports   : none (package).
// Config  : the CTRL register index is only decoded when WB_UART_TX_IRQ_EN
//           is defined; the constant is always present.
// -----------------------------------------------------------------------------
package wb_uart_tx_pkg;

   localparam int ADR_WIDTH = 32;
   localparam int DAT_WIDTH = 64;
   localparam int SEL_WIDTH = 8;

   // Word indices, decoded from adr_i[11:3]
   localparam logic [8:0] REG_TXDATA  = 9'd0;
   localparam logic [8:0] REG_STATUS  = 9'd1;
   localparam logic [8:0] REG_BAUDDIV = 9'd2;
   localparam logic [8:0] REG_CTRL    = 9'd3;

   // STATUS bit positions
   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_LEVEL_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_fifo
// Purpose : synchronous byte FIFO holding bytes waiting to be serialised.
//           Push and pop in the same cycle both take effect; a push while
//           full or a pop while empty is ignored.
// Ports   : clk_i, rst_n_i (async active-low)
//           push, din[7:0]      write side
//           pop,  dout[7:0]     read side, dout shows the head entry
//           level, full, empty  occupancy, all from registered state
// -----------------------------------------------------------------------------
module wb_uart_tx_fifo
   import wb_uart_tx_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage has no reset; only the pointers and level define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are AW bits wide so they wrap modulo DEPTH by themselves.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            level <= level + 1'b1;
         end else if (do_pop && !do_push) begin
            level <= level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
// Purpose : Wishbone classic slave fronting an 8N1 UART transmitter with a
//           byte FIFO. Registers: TXDATA (W), STATUS (R), BAUDDIV (RW) and,
//           with WB_UART_TX_IRQ_EN defined, CTRL (RW) plus the irq_o output.
// Ports   : clk_i, rst_n_i (async active-low)
//           cyc_i, stb_i, we_i, adr_i, dat_i, sel_i   bus request
//           dat_o, ack_o, err_o                       bus response (registered)
//           txd_o                                     serial line, idle high
//           irq_o (WB_UART_TX_IRQ_EN only)            FIFO drained and idle
// -----------------------------------------------------------------------------
module wb_uart_tx
   import wb_uart_tx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 433
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 cyc_i,
   input  logic                 stb_i,
   input  logic                 we_i,
   input  logic [ADR_WIDTH-1:0] adr_i,
   input  logic [DAT_WIDTH-1:0] dat_i,
   input  logic [SEL_WIDTH-1:0] sel_i,
   output logic [DAT_WIDTH-1:0] dat_o,
   output logic                 ack_o,
   output logic                 err_o,
   output logic                 txd_o
`ifdef WB_UART_TX_IRQ_EN
   ,
   output logic                 irq_o
`endif
);

   localparam int          LVL_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] RESET_DIV = 16'(DEFAULT_DIV);

   logic                 req;
   logic [8:0]           idx;
   logic                 resp_ack;
   logic                 resp_err;
   logic [DAT_WIDTH-1:0] rd_data;
   logic                 wr_push;
   logic                 wr_baud;
   logic [15:0]          baud_div;

   logic [LVL_W-1:0]     fifo_level;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [7:0]           fifo_dout;

   tx_state_t            tx_state;
   logic [15:0]          cnt;
   logic [15:0]          div_lat;
   logic [2:0]           bit_idx;
   logic [7:0]           shift;
   logic                 bit_done;
   logic                 tx_pop;
   logic                 busy;

`ifdef WB_UART_TX_IRQ_EN
   logic                 wr_ctrl;
   logic                 ctrl_irq_en;
`endif

   // Address bits outside [11:3], upper data lanes and upper selects are
   // deliberately ignored by this slave.
   logic unused_bits;
   assign unused_bits = &{1'b0, adr_i[ADR_WIDTH-1:12], adr_i[2:0],
                          dat_i[DAT_WIDTH-1:16], sel_i[SEL_WIDTH-1:2]};

   // A request already answered must not be answered again while the
   // response is still on the bus.
   assign req  = cyc_i & stb_i & ~ack_o & ~err_o;
   assign idx  = adr_i[11:3];
   assign busy = (tx_state != ST_IDLE);

   // Full is the registered level, so a pop in the same cycle does not
   // rescue a write to a full FIFO.
   always_comb begin
      resp_ack = 1'b0;
      resp_err = 1'b0;
      rd_data  = '0;
      wr_push  = 1'b0;
      wr_baud  = 1'b0;
`ifdef WB_UART_TX_IRQ_EN
      wr_ctrl  = 1'b0;
`endif
      if (req) begin
         case (idx)
            REG_TXDATA: begin
               if (!we_i) begin
                  resp_err = 1'b1;
               end else if (sel_i[0] && fifo_full) begin
                  resp_err = 1'b1;
               end else begin
                  resp_ack = 1'b1;
                  wr_push  = sel_i[0];
               end
            end
            REG_STATUS: begin
               if (we_i) begin
                  resp_err = 1'b1;
               end else begin
                  resp_ack                       = 1'b1;
                  rd_data[STAT_BUSY]             = busy;
                  rd_data[STAT_FULL]             = fifo_full;
                  rd_data[STAT_EMPTY]            = fifo_empty;
                  rd_data[STAT_LEVEL_LSB +: 8]   = 8'(fifo_level);
               end
            end
            REG_BAUDDIV: begin
               resp_ack = 1'b1;
               if (we_i) begin
                  wr_baud = 1'b1;
               end else begin
                  rd_data[15:0] = baud_div;
               end
            end
`ifdef WB_UART_TX_IRQ_EN
            REG_CTRL: begin
               resp_ack = 1'b1;
               if (we_i) begin
                  wr_ctrl = 1'b1;
               end else begin
                  rd_data[0] = ctrl_irq_en;
               end
            end
`endif
            default: resp_err = 1'b1;
         endcase
      end
   end

   // Bus response and BAUDDIV; dat_o carries data only alongside ack_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         dat_o    <= '0;
         baud_div <= RESET_DIV;
      end else begin
         ack_o <= resp_ack;
         err_o <= resp_err;
         dat_o <= rd_data;
         if (wr_baud) begin
            if (sel_i[0]) begin
               baud_div[7:0] <= dat_i[7:0];
            end
            if (sel_i[1]) begin
               baud_div[15:8] <= dat_i[15:8];
            end
         end
      end
   end

`ifdef WB_UART_TX_IRQ_EN
   // Interrupt when enabled and there is nothing left to send.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_irq_en <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         if (wr_ctrl && sel_i[0]) begin
            ctrl_irq_en <= dat_i[0];
         end
         irq_o <= ctrl_irq_en & fifo_empty & ~busy;
      end
   end
`endif

   wb_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push    (wr_push),
      .pop     (tx_pop),
      .din     (dat_i[7:0]),
      .dout    (fifo_dout),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A byte is fetched either from idle or in the last stop-bit cycle, which
   // lets consecutive frames run with no idle gap.
   assign bit_done = (cnt == div_lat);
   assign tx_pop   = ~fifo_empty &
                     ((tx_state == ST_IDLE) | ((tx_state == ST_STOP) & bit_done));

   // TX state machine. The divisor is latched per frame so a BAUDDIV write
   // mid-frame only affects the next frame.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_state <= ST_IDLE;
         txd_o    <= 1'b1;
         cnt      <= '0;
         div_lat  <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (tx_pop) begin
                  shift    <= fifo_dout;
                  div_lat  <= baud_div;
                  cnt      <= '0;
                  txd_o    <= 1'b0;
                  tx_state <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  txd_o    <= shift[0];
                  tx_state <= ST_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd_o    <= 1'b1;
                     tx_state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shift   <= {1'b0, shift[7:1]};
                     txd_o   <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (tx_pop) begin
                     shift    <= fifo_dout;
                     div_lat  <= baud_div;
                     txd_o    <= 1'b0;
                     tx_state <= ST_START;
                  end else begin
                     tx_state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               txd_o    <= 1'b1;
               tx_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_tx
// Purpose : self-checking bench for wb_uart_tx. Bus accesses come from a
//           vector table and a few hand-written sequences; every access pushes
//           its expected response onto a queue that is popped when the slave
//           answers. Serial frames are decoded and compared with the bytes
//           that were written. The CTRL/irq_o checks are compiled only when
//           WB_UART_TX_IRQ_EN is defined.
// -----------------------------------------------------------------------------
module tb_wb_uart_tx;
   import wb_uart_tx_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 cyc = 1'b0;
   logic                 stb = 1'b0;
   logic                 we = 1'b0;
   logic [ADR_WIDTH-1:0] adr = '0;
   logic [DAT_WIDTH-1:0] wdat = '0;
   logic [SEL_WIDTH-1:0] sel = '0;
   logic [DAT_WIDTH-1:0] dat_o;
   logic                 ack_o;
   logic                 err_o;
   logic                 txd_o;
`ifdef WB_UART_TX_IRQ_EN
   logic                 irq_o;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [8:0]  idx;
      logic [63:0] dat;
      logic [7:0]  sel;
      logic        exp_err;
      logic [63:0] exp_dat;
      string       name;
   } vec_t;

   typedef struct {
      logic        exp_err;
      logic [63:0] exp_dat;
      string       name;
   } exp_t;

   vec_t       vecs[$];
   exp_t       exp_q[$];
   logic [7:0] tx_q[$];

   wb_uart_tx #(
      .FIFO_DEPTH  (16),
      .DEFAULT_DIV (433)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .cyc_i   (cyc),
      .stb_i   (stb),
      .we_i    (we),
      .adr_i   (adr),
      .dat_i   (wdat),
      .sel_i   (sel),
      .dat_o   (dat_o),
      .ack_o   (ack_o),
      .err_o   (err_o),
      .txd_o   (txd_o)
`ifdef WB_UART_TX_IRQ_EN
      ,
      .irq_o   (irq_o)
`endif
   );

   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic w, input logic [8:0] i, input logic [63:0] d,
                         input logic [7:0] s, input logic e, input logic [63:0] ed,
                         input string n);
      vec_t v;
      v.we = w; v.idx = i; v.dat = d; v.sel = s;
      v.exp_err = e; v.exp_dat = ed; v.name = n;
      vecs.push_back(v);
   endtask

   // Pops the oldest expectation and compares it with the response on the bus.
   task automatic checkOutput(input logic timed_out);
      exp_t e;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("[TB] FAIL scoreboard: response with no expectation queued");
         return;
      end
      e = exp_q.pop_front();
      if (timed_out) begin
         total++; bad++;
         $display("[TB] FAIL %s_timeout: no ack/err, required %s", e.name, e.exp_err ? "err" : "ack");
         return;
      end
      checkVal({e.name, "_resp"}, {62'b0, ack_o, err_o}, e.exp_err ? 64'h1 : 64'h2);
      checkVal({e.name, "_dat"}, dat_o, e.exp_dat);
   endtask

   // One bus access; returns at #1 into the second cycle after the response,
   // once the single-cycle response has been seen to drop.
   task automatic applyStimulus(input logic w, input logic [8:0] i, input logic [63:0] d,
                                input logic [7:0] s, input logic e, input logic [63:0] ed,
                                input string n);
      exp_t x;
      int   waited;
      x.exp_err = e; x.exp_dat = ed; x.name = n;
      exp_q.push_back(x);
      @(negedge clk);
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = w;
      adr  = {20'h0, i, 3'b000};
      wdat = d;
      sel  = s;
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!(ack_o || err_o) && waited < 8);
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      checkOutput(!(ack_o || err_o));
      @(posedge clk); #1;
      checkVal({n, "_release"}, {61'b0, ack_o, err_o, |dat_o}, 64'h0);
   endtask

   // Decodes n back-to-back frames at one clock per bit (BAUDDIV=0).
   task automatic monitorFrames(input int n);
      int         waited;
      logic [7:0] rx;
      logic [7:0] exp_b;
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (txd_o !== 1'b0 && waited < 60);
      if (txd_o !== 1'b0) begin
         total++; bad++;
         $display("[TB] FAIL frame_timeout: txd_o=%b, required start bit 0", txd_o);
         return;
      end
      for (int f = 0; f < n; f++) begin
         if (f > 0) begin
            @(posedge clk); #1;
         end
         checkVal($sformatf("frame%0d_start", f), {63'b0, txd_o}, 64'h0);
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            rx[k] = txd_o;
         end
         @(posedge clk); #1;
         checkVal($sformatf("frame%0d_stop", f), {63'b0, txd_o}, 64'h1);
         if (tx_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL frame%0d_byte: got 0x%0h, required nothing", f, rx);
         end else begin
            exp_b = tx_q.pop_front();
            checkVal($sformatf("frame%0d_byte", f), {56'b0, rx}, {56'b0, exp_b});
         end
      end
   endtask

   initial begin
      logic [7:0] stream [3];
      logic       frame_bits [10];
      logic [7:0] a5;
      int         waited;

      // Reset
      #23;
      checkVal("rst_txd", {63'b0, txd_o}, 64'h1);
      checkVal("rst_resp", {62'b0, ack_o, err_o}, 64'h0);
      checkVal("rst_dat", dat_o, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Register map, illegal accesses and byte selects
      addVec(1'b0, REG_STATUS,  64'h0,          8'h00, 1'b0, 64'h4,    "status_reset");
      addVec(1'b0, REG_BAUDDIV, 64'h0,          8'h00, 1'b0, 64'h1B1,  "baud_reset");
      addVec(1'b0, REG_TXDATA,  64'h0,          8'h00, 1'b1, 64'h0,    "rd_txdata");
      addVec(1'b1, REG_STATUS,  64'hFF,         8'hFF, 1'b1, 64'h0,    "wr_status");
      addVec(1'b0, 9'd7,        64'h0,          8'h00, 1'b1, 64'h0,    "rd_idx7");
      addVec(1'b1, 9'd7,        64'h12,         8'hFF, 1'b1, 64'h0,    "wr_idx7");
      addVec(1'b1, REG_TXDATA,  64'h55,         8'hFE, 1'b0, 64'h0,    "wr_txdata_nosel");
      addVec(1'b1, REG_BAUDDIV, 64'h1234,       8'h03, 1'b0, 64'h0,    "wr_baud_full");
      addVec(1'b0, REG_BAUDDIV, 64'h0,          8'h00, 1'b0, 64'h1234, "rd_baud_full");
      addVec(1'b1, REG_BAUDDIV, 64'hBEEF,       8'h02, 1'b0, 64'h0,    "wr_baud_hi");
      addVec(1'b0, REG_BAUDDIV, 64'h0,          8'h00, 1'b0, 64'hBE34, "rd_baud_hi");
      addVec(1'b1, REG_BAUDDIV, 64'hFFFF_0003,  8'h01, 1'b0, 64'h0,    "wr_baud_lo");
      addVec(1'b0, REG_BAUDDIV, 64'h0,          8'h00, 1'b0, 64'hBE03, "rd_baud_lo");
`ifdef WB_UART_TX_IRQ_EN
      addVec(1'b0, REG_CTRL,    64'h0,          8'h00, 1'b0, 64'h0,    "rd_ctrl");
`else
      addVec(1'b0, REG_CTRL,    64'h0,          8'h00, 1'b1, 64'h0,    "rd_ctrl_unmapped");
      addVec(1'b1, REG_CTRL,    64'h1,          8'hFF, 1'b1, 64'h0,    "wr_ctrl_unmapped");
`endif
      addVec(1'b0, REG_STATUS,  64'h0,          8'h00, 1'b0, 64'h4,    "status_unchanged");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].we, vecs[i].idx, vecs[i].dat, vecs[i].sel,
                       vecs[i].exp_err, vecs[i].exp_dat, vecs[i].name);
      end

      // Strobe without cycle must be ignored entirely
      @(negedge clk);
      cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = '0; wdat = 64'h77; sel = 8'h01;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkVal($sformatf("cyc_low_noresp%0d", i), {62'b0, ack_o, err_o}, 64'h0);
      end
      stb = 1'b0; we = 1'b0;
      applyStimulus(1'b0, REG_STATUS, 64'h0, 8'h00, 1'b0, 64'h4, "status_after_cyc_low");

      // Back-to-back frames at one clock per bit, FIFO order preserved
      applyStimulus(1'b1, REG_BAUDDIV, 64'h0, 8'h03, 1'b0, 64'h0, "wr_baud0");
      stream[0] = 8'h81; stream[1] = 8'h42; stream[2] = 8'hC3;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               tx_q.push_back(stream[i]);
               applyStimulus(1'b1, REG_TXDATA, {56'b0, stream[i]}, 8'h01, 1'b0, 64'h0,
                             $sformatf("stream_wr%0d", i));
            end
         end
         begin
            monitorFrames(3);
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // 0xA5 at BAUDDIV=3: exact per-cycle waveform, start bit in N+2
      applyStimulus(1'b1, REG_BAUDDIV, 64'h3, 8'h03, 1'b0, 64'h0, "wr_baud3");
      checkVal("a5_idle", {63'b0, txd_o}, 64'h1);
      a5 = 8'hA5;
      frame_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) frame_bits[k+1] = a5[k];
      frame_bits[9] = 1'b1;
      applyStimulus(1'b1, REG_TXDATA, 64'hA5, 8'h01, 1'b0, 64'h0, "wr_a5");
      checkVal("a5_c0", {63'b0, txd_o}, {63'b0, frame_bits[0]});
      for (int i = 1; i < 40; i++) begin
         @(posedge clk); #1;
         checkVal($sformatf("a5_c%0d", i), {63'b0, txd_o}, {63'b0, frame_bits[i/4]});
      end
      @(posedge clk); #1;
      checkVal("a5_after", {63'b0, txd_o}, 64'h1);

      // Busy while a frame runs, idle again afterwards
      applyStimulus(1'b1, REG_TXDATA, 64'h3C, 8'h01, 1'b0, 64'h0, "wr_3c");
      applyStimulus(1'b0, REG_STATUS, 64'h0, 8'h00, 1'b0, 64'h5, "status_busy");
      repeat (45) @(posedge clk);
      applyStimulus(1'b0, REG_STATUS, 64'h0, 8'h00, 1'b0, 64'h4, "status_idle");

      // Fill: first byte leaves for the shifter, 17th fits, 18th rejected
      applyStimulus(1'b1, REG_BAUDDIV, 64'd200, 8'h03, 1'b0, 64'h0, "wr_baud200");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, REG_TXDATA, 64'h10 + 64'(i), 8'h01, 1'b0, 64'h0,
                       $sformatf("fill_wr%0d", i));
      end
      applyStimulus(1'b1, REG_TXDATA, 64'hEE, 8'h01, 1'b1, 64'h0, "fill_wr_overflow");
      applyStimulus(1'b0, REG_STATUS, 64'h0, 8'h00, 1'b0, 64'h1003, "status_full");

      // Asynchronous reset in the middle of the start bit
      @(posedge clk); #3;
      checkVal("midframe_txd", {63'b0, txd_o}, 64'h0);
      rst_n = 1'b0;
      #1;
      checkVal("async_rst_txd", {63'b0, txd_o}, 64'h1);
      checkVal("async_rst_resp", {62'b0, ack_o, err_o}, 64'h0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, REG_STATUS, 64'h0, 8'h00, 1'b0, 64'h4, "status_after_rst");
      applyStimulus(1'b0, REG_BAUDDIV, 64'h0, 8'h00, 1'b0, 64'h1B1, "baud_after_rst");
      checkVal("txd_after_rst", {63'b0, txd_o}, 64'h1);

`ifdef WB_UART_TX_IRQ_EN
      // Interrupt when drained: raised by CTRL, dropped by a push, back after stop
      checkVal("irq_reset", {63'b0, irq_o}, 64'h0);
      applyStimulus(1'b1, REG_BAUDDIV, 64'h1, 8'h03, 1'b0, 64'h0, "wr_baud1");
      applyStimulus(1'b1, REG_CTRL, 64'h1, 8'h01, 1'b0, 64'h0, "wr_ctrl");
      checkVal("irq_on", {63'b0, irq_o}, 64'h1);
      applyStimulus(1'b0, REG_CTRL, 64'h0, 8'h00, 1'b0, 64'h1, "rd_ctrl_set");
      applyStimulus(1'b1, REG_TXDATA, 64'h0F, 8'h01, 1'b0, 64'h0, "wr_irq_byte");
      checkVal("irq_drop", {63'b0, irq_o}, 64'h0);
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (irq_o !== 1'b1 && waited < 60);
      checkVal("irq_return", {63'b0, irq_o}, 64'h1);
      checkVal("irq_return_cycle", 64'(waited), 64'd21);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
